fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Consumer end of the control-decoder interface.
- Takes the decoder's PC and LUT control flags (PC_Jmp_Flag, PC_Beq_Flag, LUT_Write_En/Read_En/Load_Hi, Ack) and turns them into the program counter that addresses instruction memory.
- Owns the branch-target LUT written by LD_LUT_H/LD_LUT_L and read by BEQ/JMP.
- Runs the Start/Done handshake with the testbench.

Parameters:
- PC_W, 10, program counter width in bits; legal range 9..16.
- LUT_DEPTH, 16, number of branch-target entries; index is Instruction[3:0].

Ports:
- Clk  input  1  system clock; all state changes on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  testbench start request; level-sensitive.
- PC_Jmp_Flag  input  1  unconditional jump request from decoder.
- PC_Beq_Flag  input  1  taken-branch request from decoder; already qualified by accumulator==1.
- LUT_Write_En  input  1  write one half of a LUT entry.
- LUT_Read_En  input  1  LUT read qualifier for jump/branch.
- LUT_Load_Hi  input  1  1 = write upper half, 0 = write lower half.
- LUT_Index  input  4  entry select, driven from Instruction[3:0].
- LUT_Wr_Data  input  8  write data, driven from accumulator.
- Ack  input  1  halt request from decoder (HLT or all-ones instruction).
- PC  output  PC_W  instruction memory address.
- Fetch_En  output  1  high when the current PC addresses a live instruction.
- Done  output  1  program finished.
- Cycle_Count  output  16  executed-cycle counter; see Optional Feature.

Behaviour:
- State machine with three states: IDLE, RUN, HALT.
- Reset:
  - State=IDLE; PC=0; Fetch_En=0; Done=0; Cycle_Count=0.
  - All LUT entries cleared to 0.
  - Reset overrides every other input, including mid-RUN.
- IDLE:
  - PC held at 0; all decoder inputs ignored, including LUT writes.
  - Start=1 keeps IDLE.
  - First cycle with Start=0 after Start was sampled 1 moves to RUN.
  - Start never sampled high: remain IDLE.
- RUN, with Fetch_En=1 combinationally. Priority, evaluated each edge:
  1. Ack=1 -> state HALT; PC holds its current value; flags in the same cycle are ignored.
  2. (PC_Jmp_Flag or PC_Beq_Flag) and LUT_Read_En=1 -> PC = LUT[LUT_Index].
  3. Otherwise -> PC = PC+1, modulo 2^PC_W. Wrap from all-ones to 0 is silent.
- A jump/branch flag with LUT_Read_En=0 is treated as sequential (PC+1).
- LUT writes are honored only in RUN:
  - Lower half: LUT_Load_Hi=0 writes entry[7:0] = LUT_Wr_Data.
  - Upper half: LUT_Load_Hi=1 writes entry[PC_W-1:8] = LUT_Wr_Data[PC_W-9:0]; extra data bits are discarded.
  - The untouched half keeps its value.
- LUT read and write to the same index in the same cycle: the PC takes the old entry value; the write lands at the edge.
- LUT_Index >= LUT_DEPTH: writes dropped; reads return 0.
- Start=1 while in RUN: restart. Next state IDLE, PC=0; the LUT is preserved.
- HALT:
  - Done=1 and Fetch_En=0; PC frozen; all decoder inputs ignored.
  - Start=1 -> IDLE with PC=0 and Done=0 on the next cycle; LUT preserved.
- Latency: the PC update is visible one cycle after the flags are sampled. Done rises one cycle after Ack is sampled in RUN.
- All outputs are registered except Fetch_En, which is decoded from state.

Optional Feature:
- Macro: FETCH_CYCLE_COUNT_EN.
- Defined:
  - Cycle_Count increments by 1 on each edge spent in RUN, including the edge that takes Ack.
  - It saturates at 16'hFFFF.
  - It clears on Reset and on the IDLE->RUN transition.
  - It holds in HALT so the testbench can read it alongside Done.
- Not defined: Cycle_Count is tied to 0 and no counter flops are inferred.

Test Plan:
- Reset, then Start high 2 cycles, then low, then 5 cycles with no flags -> PC sequence 0,1,2,3,4,5; Fetch_En=1; Done=0.
- Write sequence:
  - LUT_Write_En with Load_Hi=0, Index=3, Data=8'h2A.
  - Then Load_Hi=1, Index=3, Data=8'h01.
  - Then PC_Jmp_Flag=1 with LUT_Read_En=1 and Index=3.
  - Expect next PC=10'h12A.
- PC_Beq_Flag=1 with Read_En=1 on Index=5 (never written) -> PC=0. Same flag with Read_En=0 -> PC+1.
- Same-cycle write Index=2 Data=8'h40 and jump via Index=2 (old value 8'h10) -> PC=10'h010. A later jump via Index 2 -> PC=10'h040.
- Ack at PC=7:
  - Expect Done=1 next cycle; PC stays 7; jump flags ignored.
  - Then Start pulse -> PC=0, Done=0, and RUN resumes.
  - With FETCH_CYCLE_COUNT_EN, Cycle_Count = 8 while halted.
- Reset asserted mid-RUN at PC=300 -> next cycle PC=0, IDLE, Done=0, and LUT entries read back 0 after restart.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: turns decoder control flags into the instruction-memory PC,
// owns the branch-target LUT and runs the Start/Done handshake.
// Optional feature macro: FETCH_CYCLE_COUNT_EN (enables the RUN-cycle counter;
// when undefined Cycle_Count is tied to zero).
module fetch_sequencer #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            PC_Jmp_Flag,
    input  logic            PC_Beq_Flag,
    input  logic            LUT_Write_En,
    input  logic            LUT_Read_En,
    input  logic            LUT_Load_Hi,
    input  logic [3:0]      LUT_Index,
    input  logic [7:0]      LUT_Wr_Data,
    input  logic            Ack,
    output logic [PC_W-1:0] PC,
    output logic            Fetch_En,
    output logic            Done,
    output logic [15:0]     Cycle_Count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [PC_W-1:0] pc_reg, pc_next;
    logic            done_reg, done_next;
    // Remembers that Start was seen high while idle, so the falling level launches RUN.
    logic            start_seen_reg, start_seen_next;

    // Branch-target LUT: one register per entry so reset can clear every entry.
    logic [PC_W-1:0] lut_q [LUT_DEPTH];
    logic [PC_W-1:0] lut_rd_data;
    logic            lut_wr;

    // Writes only land while running; decoder activity elsewhere is ignored.
    assign lut_wr = (state_reg == ST_RUN) && LUT_Write_En;

    genvar gi;
    generate
        for (gi = 0; gi < LUT_DEPTH; gi++) begin : g_lut
            logic [PC_W-1:0] entry_reg;

            // Half-entry write; the other half keeps its value.
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    entry_reg <= '0;
                end else if (lut_wr && (LUT_Index == 4'(gi))) begin
                    if (LUT_Load_Hi) begin
                        entry_reg[PC_W-1:8] <= LUT_Wr_Data[PC_W-9:0];
                    end else begin
                        entry_reg[7:0] <= LUT_Wr_Data;
                    end
                end
            end

            assign lut_q[gi] = entry_reg;
        end
    endgenerate

    // Read mux; an index with no backing entry reads as zero. The read sees the
    // pre-edge value, so a same-cycle write to the same index is not forwarded.
    always_comb begin
        lut_rd_data = '0;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            if (LUT_Index == 4'(i)) begin
                lut_rd_data = lut_q[i];
            end
        end
    end

    // State, PC, Done and start tracking registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg      <= ST_IDLE;
            pc_reg         <= '0;
            done_reg       <= 1'b0;
            start_seen_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            done_reg       <= done_next;
            start_seen_reg <= start_seen_next;
        end
    end

    // Next-state and next-PC selection.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        done_next       = done_reg;
        start_seen_next = start_seen_reg;
        case (state_reg)
            ST_IDLE: begin
                pc_next   = '0;
                done_next = 1'b0;
                if (Start) begin
                    start_seen_next = 1'b1;
                end else if (start_seen_reg) begin
                    state_next      = ST_RUN;
                    start_seen_next = 1'b0;
                end
            end
            ST_RUN: begin
                done_next = 1'b0;
                if (Start) begin
                    // Restart: back to idle with PC cleared, LUT untouched.
                    state_next      = ST_IDLE;
                    pc_next         = '0;
                    start_seen_next = 1'b1;
                end else if (Ack) begin
                    // Halt wins over any jump/branch in the same cycle.
                    state_next = ST_HALT;
                    done_next  = 1'b1;
                end else if ((PC_Jmp_Flag || PC_Beq_Flag) && LUT_Read_En) begin
                    pc_next = lut_rd_data;
                end else begin
                    pc_next = pc_reg + {{(PC_W-1){1'b0}}, 1'b1};
                end
            end
            ST_HALT: begin
                done_next = 1'b1;
                if (Start) begin
                    state_next      = ST_IDLE;
                    pc_next         = '0;
                    done_next       = 1'b0;
                    start_seen_next = 1'b1;
                end
            end
            default: begin
                state_next      = ST_IDLE;
                pc_next         = '0;
                done_next       = 1'b0;
                start_seen_next = 1'b0;
            end
        endcase
    end

    assign PC       = pc_reg;
    assign Done     = done_reg;
    assign Fetch_En = (state_reg == ST_RUN);

`ifdef FETCH_CYCLE_COUNT_EN
    logic [15:0] cycle_count_reg;

    // Counts RUN edges (including the Ack edge), saturating; cleared on launch.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cycle_count_reg <= '0;
        end else if ((state_reg == ST_IDLE) && (state_next == ST_RUN)) begin
            cycle_count_reg <= '0;
        end else if ((state_reg == ST_RUN) && (cycle_count_reg != 16'hFFFF)) begin
            cycle_count_reg <= cycle_count_reg + 16'd1;
        end
    end

    assign Cycle_Count = cycle_count_reg;
`else
    assign Cycle_Count = '0;
`endif

endmodule
